pixel_readout_fifo: RTL and testbench
=====================================

PIXEL_READOUT_FIFO -- requirements
Module: pixel_readout_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; a power of two, 2..64.
REQ-002 SHALL have parameter ROW_WORDS, default 4, pixel words per sensor row; 1..1024.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pixelDataIn  input  16  pixel word read from the pixel array output bus.
REQ-006 SHALL have port pixelValid  input  1  pixelDataIn carries a valid word this cycle.
REQ-007 SHALL have port outData  output  16  head-of-FIFO pixel word.
REQ-008 SHALL have port outValid  output  1  outData/outLast valid; high exactly when the FIFO is non-empty.
REQ-009 SHALL have port outReady  input  1  consumer accepts the word; a pop occurs when outValid and outReady are both high.
REQ-010 SHALL have port outLast  output  1  head word is the last word of a row.
REQ-011 SHALL have port overflow  output  1  sticky flag: at least one word dropped since reset.
REQ-012 SHALL have port fillLevel  output  clog2(DEPTH)+1  current entry count, 0..DEPTH.

Function
REQ-013 SHALL store each entry as 17 bits: 16 data bits plus 1 last-of-row flag.
REQ-014 SHALL push when pixelValid=1 and (not full, or full with a pop in the same cycle).
REQ-015 SHALL drop the word and set overflow=1 on the next edge when pixelValid=1, the FIFO is full and no pop occurs in that cycle.
REQ-016 SHALL advance the column counter on every pixelValid, including dropped words, so row framing tracks sensor timing.
REQ-017 SHALL give column counter values 0..ROW_WORDS-1, wrapping from ROW_WORDS-1 to 0; the entry flag is 1 when the counter equals ROW_WORDS-1.
REQ-018 SHALL present data first-word-fall-through: outData and outLast equal the head entry combinationally from storage, with no extra register stage.
REQ-019 SHALL give a push-to-outValid latency of 1 cycle: a word pushed at edge N is visible after edge N.
REQ-020 SHALL not bypass when empty: a simultaneous push and outReady into an empty FIFO pops nothing; outValid rises next cycle.
REQ-021 SHALL keep fillLevel unchanged on a simultaneous push and pop.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL hold outData stable while outValid=1 and outReady=0.

Reset
REQ-024 SHALL, on reset=1 at a rising edge, clear pointers, fillLevel=0, outValid=0, outLast=0, overflow=0 and column counter=0.
REQ-025 SHALL let reset override any push or pop in the same cycle; in-flight data is discarded.
REQ-026 SHALL not clear storage contents on reset; outData is don't-care while outValid=0.

Configuration
REQ-027 SHALL, with macro PIXEL_BLACK_LEVEL_EN defined, add port blackLevel  input  16  and store max(pixelDataIn - blackLevel, 0), saturating at 0 and never wrapping.
REQ-028 SHALL, without PIXEL_BLACK_LEVEL_EN, omit the blackLevel port and store pixelDataIn unmodified.

Verification
REQ-029 SHALL cover: reset, then 4 pushes of 0x0001..0x0004 with outReady=0 -> fillLevel=4; outLast=1 only on 0x0004; outValid rises 1 cycle after the first push.
REQ-030 SHALL cover: DEPTH=8, 9 consecutive pushes with outReady=0 -> fillLevel=8; 9th word dropped; overflow=1 and stays 1 until reset.
REQ-031 SHALL cover: FIFO full, pixelValid=1 and outReady=1 together for 10 cycles -> no overflow; fillLevel stays 8; output order matches input order.
REQ-032 SHALL cover: 20 words with outReady toggling every cycle -> all 20 received in order; pointers wrap; outLast on words 4, 8, 12, 16, 20.
REQ-033 SHALL cover: reset asserted for one cycle with fillLevel=5 -> next cycle fillLevel=0, outValid=0, overflow=0; the next pushed word gets column 0.
REQ-034 SHALL cover: PIXEL_BLACK_LEVEL_EN with blackLevel=0x0100; inputs 0x0180 and 0x0050 -> outputs 0x0080 and 0x0000.

Source files
------------

// File: rtl/pixel_readout_fifo.sv
// -----------------------------------------------------------------------------
// pixel_readout_fifo
//   Buffers pixel words read off the sensor array bus and hands them to a
//   ready/valid consumer. Each entry carries a last-of-row flag, derived from
//   a column counter that follows sensor timing (it advances on every
//   pixelValid, even when the word is dropped).
//   Head data is first-word-fall-through, read straight from storage.
//
// Optional feature macro: PIXEL_BLACK_LEVEL_EN
//   When defined, a blackLevel input is added. The stored word is
//   max(pixelDataIn - blackLevel, 0).
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   blackLevel   [15:0] black level to subtract (PIXEL_BLACK_LEVEL_EN only)
//   pixelDataIn  [15:0] pixel word from the array bus
//   pixelValid   pixelDataIn is valid this cycle
//   outData      [15:0] head-of-FIFO word
//   outValid     FIFO non-empty
//   outReady     consumer accepts; a pop happens when outValid & outReady
//   outLast      head word is the last word of a row
//   overflow     sticky: a word has been dropped since reset
//   fillLevel    entry count, 0..DEPTH
// -----------------------------------------------------------------------------
module pixel_readout_fifo #(
  parameter int DEPTH     = 8,
  parameter int ROW_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef PIXEL_BLACK_LEVEL_EN
  input  logic [15:0]              blackLevel,
`endif
  input  logic [15:0]              pixelDataIn,
  input  logic                     pixelValid,
  output logic [15:0]              outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     outLast,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fillLevel
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int COL_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_WORDS - 1);

  // Entry layout: {last, data[15:0]}
  logic [16:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [COL_W-1:0] r_col;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic [15:0]      w_pix;
  logic             w_last;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Only a registered entry can pop, so an empty FIFO never bypasses.
  assign w_pop   = !w_empty && outReady;
  // When full, a pop in the same cycle frees the slot the push needs.
  assign w_push  = pixelValid && (!w_full || w_pop);
  assign w_last  = (r_col == COL_LAST);

`ifdef PIXEL_BLACK_LEVEL_EN
  // The subtraction saturates at zero and never wraps.
  assign w_pix = (pixelDataIn > blackLevel) ? (pixelDataIn - blackLevel) : 16'h0000;
`else
  assign w_pix = pixelDataIn;
`endif

  // Storage is not reset. A stale head is masked by outValid.
  always_ff @(posedge clk) begin
    if (w_push && !reset)
      r_mem[r_wptr] <= {w_last, w_pix};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_col      <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      // Framing follows the sensor: a dropped word still uses a column.
      if (pixelValid)
        r_col <= w_last ? '0 : r_col + COL_W'(1);

      if (pixelValid && !w_push)
        r_overflow <= 1'b1;
    end
  end

  assign outValid  = !w_empty;
  assign outData   = r_mem[r_rptr][15:0];
  assign outLast   = !w_empty && r_mem[r_rptr][16];
  assign overflow  = r_overflow;
  assign fillLevel = r_count;

endmodule

// File: tb/tb_pixel_readout_fifo.sv
module tb_pixel_readout_fifo;
  localparam int DEPTH     = 8;
  localparam int ROW_WORDS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pixelDataIn = '0;
  logic        pixelValid = 1'b0;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        outLast;
  logic        overflow;
  logic [$clog2(DEPTH):0] fillLevel;
  logic [15:0] blackLevel = '0;

  pixel_readout_fifo #(.DEPTH(DEPTH), .ROW_WORDS(ROW_WORDS)) dut (
    .clk(clk),
    .reset(reset),
`ifdef PIXEL_BLACK_LEVEL_EN
    .blackLevel(blackLevel),
`endif
    .pixelDataIn(pixelDataIn),
    .pixelValid(pixelValid),
    .outData(outData),
    .outValid(outValid),
    .outReady(outReady),
    .outLast(outLast),
    .overflow(overflow),
    .fillLevel(fillLevel)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;

  // Reference model: a queue of {last, data}, a column index, a sticky flag.
  logic [16:0] q[$];
  int          m_col = 0;
  logic        m_ovf = 1'b0;
  // Words the DUT handed over (observed at handshake).
  logic [16:0] rx[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stored_value(input logic [15:0] d, input logic [15:0] bl);
`ifdef PIXEL_BLACK_LEVEL_EN
    int v;
    v = int'(d) - int'(bl);
    return (v < 0) ? 16'h0000 : 16'(v);
`else
    return d + 16'(bl & 16'h0000);
`endif
  endfunction

  task automatic check_outputs();
    chk("outValid", {31'b0, outValid}, {31'b0, q.size() != 0});
    chk("fillLevel", 32'(fillLevel), 32'(q.size()));
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    if (q.size() != 0) begin
      chk("outData", {16'b0, outData}, {16'b0, q[0][15:0]});
      chk("outLast", {31'b0, outLast}, {31'b0, q[0][16]});
    end else begin
      chk("outLast_empty", {31'b0, outLast}, 32'd0);
    end
    if (outValid === 1'b1 && outReady === 1'b1) rx.push_back({outLast, outData});
  endtask

  task automatic model_edge(input logic v, input logic [15:0] d, input logic rdy, input logic [15:0] bl);
    logic pop, push;
    pop  = (q.size() != 0) && rdy;
    push = v && ((q.size() < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (push) q.push_back({(m_col == ROW_WORDS - 1), stored_value(d, bl)});
    if (v && !push) m_ovf = 1'b1;
    if (v) m_col = (m_col + 1) % ROW_WORDS;
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic rdy);
    @(negedge clk);
    pixelValid = v; pixelDataIn = d; outReady = rdy;
    #1 check_outputs();
    @(posedge clk);
    model_edge(v, d, rdy, blackLevel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pixelValid = 1'($urandom); pixelDataIn = 16'($urandom); outReady = 1'b1;
    @(posedge clk);
    q.delete(); m_col = 0; m_ovf = 1'b0;
    #1 reset = 1'b0; pixelValid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    step(1'b0, 16'h0, 1'b0);
    chk("rst_fill", 32'(fillLevel), 32'd0);
    chk("rst_valid", {31'b0, outValid}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);

    // Four pushes, consumer stalled
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("four_fill", 32'(fillLevel), 32'd4);
    chk("four_head", {16'b0, outData}, 32'h0001);
    chk("four_head_last", {31'b0, outLast}, 32'd0);
    rx.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    chk("four_rx_n", 32'(rx.size()), 32'd4);
    if (rx.size() == 4) begin
      chk("four_w3", {15'b0, rx[2]}, 32'h00003);
      chk("four_w4", {15'b0, rx[3]}, 32'h10004);
    end

    // Overflow: nine pushes into depth 8
    do_reset();
    for (int i = 1; i <= 9; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("ovf_fill", 32'(fillLevel), 32'd8);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 12; i++) step(1'b0, 16'h0, 1'b1);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    chk("ovf_drained", 32'(fillLevel), 32'd0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0200 + i), 1'b0);
    rx.delete();
    for (int i = 8; i < 18; i++) step(1'b1, 16'(16'h0200 + i), 1'b1);
    step(1'b0, 16'h0, 1'b0);
    chk("full_fill", 32'(fillLevel), 32'd8);
    chk("full_ovf", {31'b0, overflow}, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);
    chk("full_rx_n", 32'(rx.size()), 32'd18);
    for (int i = 0; i < rx.size(); i++)
      chk("full_order", {16'b0, rx[i][15:0]}, 32'(16'h0200 + i));

    // 20 words, consumer ready toggling every cycle
    do_reset();
    rx.delete();
    for (int i = 0; i < 40; i++)
      step((i % 2) == 0, 16'(i / 2 + 1), 1'((i + 1) % 2));
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);
    chk("tog_rx_n", 32'(rx.size()), 32'd20);
    for (int i = 0; i < rx.size(); i++)
      chk("tog_word", {15'b0, rx[i]}, {15'b0, ((i + 1) % 4) == 0, 16'(i + 1)});

    // Reset with five entries, then framing restarts at column 0
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 16'(16'h0300 + i), 1'b0); // column 5 -> 2 pending
    step(1'b0, 16'h0, 1'b1); // pop one: five left
    step(1'b0, 16'h0, 1'b0);
    chk("pre_rst_fill", 32'(fillLevel), 32'd5);
    do_reset();
    step(1'b0, 16'h0, 1'b0);
    chk("post_rst_fill", 32'(fillLevel), 32'd0);
    chk("post_rst_valid", {31'b0, outValid}, 32'd0);
    chk("post_rst_ovf", {31'b0, overflow}, 32'd0);
    rx.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(16'h0400 + i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1);
    chk("post_rst_rx_n", 32'(rx.size()), 32'd4);
    if (rx.size() == 4) begin
      chk("post_rst_col0", {31'b0, rx[0][16]}, 32'd0);
      chk("post_rst_col3", {31'b0, rx[3][16]}, 32'd1);
    end

`ifdef PIXEL_BLACK_LEVEL_EN
    do_reset();
    blackLevel = 16'h0100;
    rx.delete();
    step(1'b1, 16'h0180, 1'b0);
    step(1'b1, 16'h0050, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
    chk("blk_rx_n", 32'(rx.size()), 32'd2);
    if (rx.size() == 2) begin
      chk("blk_w0", {16'b0, rx[0][15:0]}, 32'h0080);
      chk("blk_w1", {16'b0, rx[1][15:0]}, 32'h0000);
    end
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
`ifdef PIXEL_BLACK_LEVEL_EN
      blackLevel = 16'($urandom_range(0, 16'h0400));
`endif
      step(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom_range(0, 99) < 45));
      if (($urandom_range(0, 199)) == 0) do_reset();
    end
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  // Watchdog: the directed sequence is bounded; this only guards a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $fatal(1, "timeout");
  end
endmodule
